// File: rtl/error_ctrl_if.sv
// Error controller bus: CPU error inputs, PCU handshake, statistics and log read port.
// master: CPU/PCU side driving requests; slave: the error_ctrl block.
interface error_ctrl_if #(
    parameter int unsigned CNT_W = 8
);
    logic [3:0]       cpu_error;
    logic [31:0]      err_pc;
    logic             pcu_ready;
    logic             pcu_resume;
    logic             pcu_clear_cnt;
    logic             cpu_stall;
    logic             err_valid;
    logic [3:0]       err_code;
    logic [31:0]      err_pc_out;
    logic [CNT_W-1:0] cnt_div;
    logic [CNT_W-1:0] cnt_mem;
    logic [CNT_W-1:0] cnt_opc;
    logic             err_lost;
    logic [1:0]       log_idx;
    logic [35:0]      log_rdata;

    modport master (
        output cpu_error, err_pc, pcu_ready, pcu_resume, pcu_clear_cnt, log_idx,
        input  cpu_stall, err_valid, err_code, err_pc_out,
               cnt_div, cnt_mem, cnt_opc, err_lost, log_rdata
    );

    modport slave (
        input  cpu_error, err_pc, pcu_ready, pcu_resume, pcu_clear_cnt, log_idx,
        output cpu_stall, err_valid, err_code, err_pc_out,
               cnt_div, cnt_mem, cnt_opc, err_lost, log_rdata
    );
endinterface

// File: rtl/error_ctrl.sv
// Error-handling controller: captures the first CPU error, stalls the CPU,
// reports the record to the PCU, waits for resume, drains the pipeline and
// keeps saturating per-class error statistics.
// Optional ERROR_LOG_EN: 4-entry circular log of captured {code, pc}.
module error_ctrl #(
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned DRAIN_CYC = 3
) (
    input  logic       clk,
    input  logic       rst,
    error_ctrl_if.slave bus
);
    localparam int unsigned DRAIN_W    = 4;
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYC - 1);
    localparam logic [3:0] CODE_DIV = 4'd1;
    localparam logic [3:0] CODE_MEM = 4'd2;
    localparam logic [3:0] CODE_OPC = 4'd3;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        REPORT = 2'd1,
        HALT   = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    state_t             state;
    logic [DRAIN_W-1:0] drain_cnt;
    logic               capture;
    logic               err_in;

    assign err_in  = (bus.cpu_error != 4'd0);
    assign capture = (state == RUN) && err_in;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Control FSM with registered stall/valid and latched error record.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= RUN;
            drain_cnt      <= '0;
            bus.cpu_stall  <= 1'b0;
            bus.err_valid  <= 1'b0;
            bus.err_code   <= '0;
            bus.err_pc_out <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (capture) begin
                        state          <= REPORT;
                        bus.err_code   <= bus.cpu_error;
                        bus.err_pc_out <= bus.err_pc;
                        bus.cpu_stall  <= 1'b1;
                        bus.err_valid  <= 1'b1;
                    end
                end
                REPORT: begin
                    if (bus.pcu_ready) begin
                        state         <= HALT;
                        bus.err_valid <= 1'b0;
                    end
                end
                HALT: begin
                    if (bus.pcu_resume) begin
                        state     <= DRAIN;
                        drain_cnt <= DRAIN_LOAD;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0) begin
                        state         <= RUN;
                        bus.cpu_stall <= 1'b0;
                    end else begin
                        drain_cnt <= drain_cnt - DRAIN_W'(1);
                    end
                end
                default: begin
                    state         <= RUN;
                    bus.cpu_stall <= 1'b0;
                    bus.err_valid <= 1'b0;
                end
            endcase
        end
    end

    // Per-class saturating counters and sticky lost flag; clear has priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.cnt_div  <= '0;
            bus.cnt_mem  <= '0;
            bus.cnt_opc  <= '0;
            bus.err_lost <= 1'b0;
        end else if (bus.pcu_clear_cnt) begin
            bus.cnt_div  <= '0;
            bus.cnt_mem  <= '0;
            bus.cnt_opc  <= '0;
            bus.err_lost <= 1'b0;
        end else begin
            if (capture) begin
                case (bus.cpu_error)
                    CODE_DIV: bus.cnt_div <= sat_inc(bus.cnt_div);
                    CODE_MEM: bus.cnt_mem <= sat_inc(bus.cnt_mem);
                    CODE_OPC: bus.cnt_opc <= sat_inc(bus.cnt_opc);
                    default:  ;
                endcase
            end
            if ((state != RUN) && err_in) begin
                bus.err_lost <= 1'b1;
            end
        end
    end

`ifdef ERROR_LOG_EN
    logic [35:0] log_mem [4];
    logic [1:0]  wp;
    logic [1:0]  rd_ptr;

    // Circular capture log, newest entry just below the write pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp <= '0;
            for (int i = 0; i < 4; i++) log_mem[i] <= '0;
        end else if (bus.pcu_clear_cnt) begin
            wp <= '0;
            for (int i = 0; i < 4; i++) log_mem[i] <= '0;
        end else if (capture) begin
            log_mem[wp] <= {bus.cpu_error, bus.err_pc};
            wp          <= wp + 2'd1;
        end
    end

    assign rd_ptr        = 2'(wp - 2'd1 - bus.log_idx);
    assign bus.log_rdata = log_mem[rd_ptr];
`else
    logic unused_log_idx;
    assign unused_log_idx = ^bus.log_idx;
    assign bus.log_rdata  = '0;
`endif

endmodule

// File: tb/tb_error_ctrl.sv
// Directed self-checking bench for error_ctrl (CNT_W=2, DRAIN_CYC=3).
module tb_error_ctrl;
    localparam int unsigned CNT_W     = 2;
    localparam int unsigned DRAIN_CYC = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    error_ctrl_if #(.CNT_W(CNT_W)) bus();

    error_ctrl #(.CNT_W(CNT_W), .DRAIN_CYC(DRAIN_CYC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic capture(input logic [3:0] code, input logic [31:0] pc);
        bus.cpu_error = code;
        bus.err_pc    = pc;
        tick();
        bus.cpu_error = 4'd0;
    endtask

    // Accept the record, resume, and wait out the drain back to RUN.
    task automatic handshake();
        bus.pcu_ready = 1'b1;
        tick();
        bus.pcu_ready  = 1'b0;
        bus.pcu_resume = 1'b1;
        tick();
        bus.pcu_resume = 1'b0;
        repeat (DRAIN_CYC) tick();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stall"}, 36'(bus.cpu_stall), 36'd0);
        chk({tag, "_valid"}, 36'(bus.err_valid), 36'd0);
        chk({tag, "_code"},  36'(bus.err_code), 36'd0);
        chk({tag, "_pc"},    36'(bus.err_pc_out), 36'd0);
        chk({tag, "_div"},   36'(bus.cnt_div), 36'd0);
        chk({tag, "_mem"},   36'(bus.cnt_mem), 36'd0);
        chk({tag, "_opc"},   36'(bus.cnt_opc), 36'd0);
        chk({tag, "_lost"},  36'(bus.err_lost), 36'd0);
        chk({tag, "_log"},   bus.log_rdata, 36'd0);
    endtask

    initial begin
        bus.cpu_error     = 4'd0;
        bus.err_pc        = 32'd0;
        bus.pcu_ready     = 1'b0;
        bus.pcu_resume    = 1'b0;
        bus.pcu_clear_cnt = 1'b0;
        bus.log_idx       = 2'd0;

        // Reset state
        #12;
        chk_all_zero("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        // Ready in RUN does nothing
        bus.pcu_ready = 1'b1;
        tick();
        bus.pcu_ready = 1'b0;
        chk("run_ready_valid", 36'(bus.err_valid), 36'd0);
        chk("run_ready_stall", 36'(bus.cpu_stall), 36'd0);

        // First capture: mem error at 0x40
        capture(4'd2, 32'h0000_0040);
        chk("cap_stall", 36'(bus.cpu_stall), 36'd1);
        chk("cap_valid", 36'(bus.err_valid), 36'd1);
        chk("cap_code",  36'(bus.err_code), 36'd2);
        chk("cap_pc",    36'(bus.err_pc_out), 36'h40);
        chk("cap_mem",   36'(bus.cnt_mem), 36'd1);
        chk("cap_lost",  36'(bus.err_lost), 36'd0);

        // Stall in REPORT with new errors and an ignored resume
        for (int i = 0; i < 5; i++) begin
            bus.cpu_error  = (i % 2 == 0) ? 4'd3 : 4'd0;
            bus.pcu_resume = (i == 2);
            tick();
        end
        bus.cpu_error  = 4'd0;
        bus.pcu_resume = 1'b0;
        chk("rep_code",  36'(bus.err_code), 36'd2);
        chk("rep_pc",    36'(bus.err_pc_out), 36'h40);
        chk("rep_valid", 36'(bus.err_valid), 36'd1);
        chk("rep_lost",  36'(bus.err_lost), 36'd1);
        chk("rep_opc",   36'(bus.cnt_opc), 36'd0);

        // Accept -> HALT
        bus.pcu_ready = 1'b1;
        tick();
        chk("halt_valid", 36'(bus.err_valid), 36'd0);
        chk("halt_stall", 36'(bus.cpu_stall), 36'd1);
        tick();
        bus.pcu_ready = 1'b0;
        chk("halt_hold_stall", 36'(bus.cpu_stall), 36'd1);
        chk("halt_hold_valid", 36'(bus.err_valid), 36'd0);

        // Resume pulse -> exactly DRAIN_CYC stall cycles
        bus.pcu_resume = 1'b1;
        tick();
        bus.pcu_resume = 1'b0;
        chk("drain1", 36'(bus.cpu_stall), 36'd1);
        tick();
        chk("drain2", 36'(bus.cpu_stall), 36'd1);
        tick();
        chk("drain3", 36'(bus.cpu_stall), 36'd1);
        tick();
        chk("drain_done", 36'(bus.cpu_stall), 36'd0);

        // Capture on first RUN cycle
        capture(4'd1, 32'h0000_0080);
        chk("div_code",  36'(bus.err_code), 36'd1);
        chk("div_cnt",   36'(bus.cnt_div), 36'd1);
        chk("div_valid", 36'(bus.err_valid), 36'd1);
        handshake();

        // Clear counters and lost flag in RUN
        bus.pcu_clear_cnt = 1'b1;
        tick();
        bus.pcu_clear_cnt = 1'b0;
        chk("clr_lost",  36'(bus.err_lost), 36'd0);
        chk("clr_div",   36'(bus.cnt_div), 36'd0);
        chk("clr_mem",   36'(bus.cnt_mem), 36'd0);
        chk("clr_stall", 36'(bus.cpu_stall), 36'd0);

        // Opcode counter saturation at 3
        for (int i = 0; i < 5; i++) begin
            capture(4'd3, 32'h100 + 32'(i));
            chk($sformatf("sat_opc%0d", i), 36'(bus.cnt_opc), 36'((i < 3) ? i + 1 : 3));
            handshake();
        end

        // Clear coincident with a capture: clear wins, capture still reported
        bus.cpu_error     = 4'd3;
        bus.err_pc        = 32'h200;
        bus.pcu_clear_cnt = 1'b1;
        tick();
        bus.cpu_error     = 4'd0;
        bus.pcu_clear_cnt = 1'b0;
        chk("clrcap_opc",   36'(bus.cnt_opc), 36'd0);
        chk("clrcap_valid", 36'(bus.err_valid), 36'd1);
        chk("clrcap_code",  36'(bus.err_code), 36'd3);

        // Into DRAIN, then asynchronous reset
        bus.pcu_ready = 1'b1;
        tick();
        bus.pcu_ready  = 1'b0;
        bus.pcu_resume = 1'b1;
        tick();
        bus.pcu_resume = 1'b0;
        chk("pre_rst_stall", 36'(bus.cpu_stall), 36'd1);
        rst = 1'b1;
        #1;
        chk_all_zero("async_rst");
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_stall", 36'(bus.cpu_stall), 36'd0);

        // Reserved code: captured, reported, not counted
        capture(4'd7, 32'h0000_0ABC);
        chk("rsv_code",  36'(bus.err_code), 36'd7);
        chk("rsv_pc",    36'(bus.err_pc_out), 36'hABC);
        chk("rsv_valid", 36'(bus.err_valid), 36'd1);
        chk("rsv_div",   36'(bus.cnt_div), 36'd0);
        chk("rsv_mem",   36'(bus.cnt_mem), 36'd0);
        chk("rsv_opc",   36'(bus.cnt_opc), 36'd0);
        handshake();

        // Log: clear, then five captures
        bus.pcu_clear_cnt = 1'b1;
        tick();
        bus.pcu_clear_cnt = 1'b0;
        bus.log_idx = 2'd0;
        #1;
        chk("log_empty", bus.log_rdata, 36'd0);
        capture(4'd1, 32'h10); handshake();
        capture(4'd2, 32'h20); handshake();
        capture(4'd3, 32'h30); handshake();
        capture(4'd1, 32'h40); handshake();
        capture(4'd2, 32'h50); handshake();
`ifdef ERROR_LOG_EN
        bus.log_idx = 2'd0; #1;
        chk("log_idx0", bus.log_rdata, {4'd2, 32'h50});
        bus.log_idx = 2'd1; #1;
        chk("log_idx1", bus.log_rdata, {4'd1, 32'h40});
        bus.log_idx = 2'd3; #1;
        chk("log_idx3", bus.log_rdata, {4'd2, 32'h20});
`else
        bus.log_idx = 2'd0; #1;
        chk("log_off0", bus.log_rdata, 36'd0);
        bus.log_idx = 2'd3; #1;
        chk("log_off3", bus.log_rdata, 36'd0);
`endif
        chk("log_cnt_div", 36'(bus.cnt_div), 36'd2);
        chk("log_cnt_mem", 36'(bus.cnt_mem), 36'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/error_ctrl.md
Name: error_ctrl

Overview:
Sequential error-handling controller between the CPU's combinational error encoder and the PCU. It captures the first non-zero CPU error code with its faulting PC and stalls the CPU. It reports the record to the PCU over a valid/ready handshake, then holds the CPU halted until the PCU orders a resume. It then drains the pipeline for a fixed number of cycles and keeps saturating per-class error statistics.

Parameters:
CNT_W, 8, width of each per-class saturating error counter
DRAIN_CYC, 3, stall cycles held after resume before returning to RUN (1..15)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
cpu_error  in  4  encoded error: 0 none, 1 div-by-zero, 2 memory access, 3 opcode, 4..15 reserved
err_pc  in  32  PC of the instruction associated with cpu_error
pcu_ready  in  1  PCU accepts the error record
pcu_resume  in  1  PCU orders the CPU to restart (single-cycle pulse or level)
pcu_clear_cnt  in  1  clear counters and err_lost
cpu_stall  out  1  freeze CPU pipeline
err_valid  out  1  error record valid toward PCU
err_code  out  4  latched error code
err_pc_out  out  32  latched faulting PC
cnt_div  out  CNT_W  div-by-zero count
cnt_mem  out  CNT_W  memory-access count
cnt_opc  out  CNT_W  opcode count
err_lost  out  1  sticky: an error arrived while not in RUN
log_idx  in  2  log read index (ERROR_LOG_EN)
log_rdata  out  36  {code, pc} log entry (ERROR_LOG_EN)

Behaviour:
- Reset (async, rst=1): state=RUN, all outputs 0, counters 0, err_code=0, err_pc_out=0, drain counter 0.
- States: RUN, REPORT, HALT, DRAIN. Encoded state is registered. cpu_stall = (state != RUN), decoded from registered state, so it has no combinational path from cpu_error.
- RUN: at a clock edge with cpu_error != 0:
  - latch err_code <= cpu_error and err_pc_out <= err_pc;
  - go to REPORT;
  - cpu_stall rises the following cycle, giving one-cycle detect-to-stall latency.
- REPORT: err_valid=1.
  - At an edge with pcu_ready=1: go to HALT.
  - err_code and err_pc_out stay stable while err_valid=1.
  - pcu_resume is ignored in REPORT.
- HALT: err_valid=0. At an edge with pcu_resume=1: load drain counter with DRAIN_CYC-1, go to DRAIN.
- DRAIN: drain counter decrements each cycle. At the edge where the counter equals 0, go to RUN. cpu_stall stays high for exactly DRAIN_CYC cycles in DRAIN.
- err_code and err_pc_out hold their last value until the next capture.
- Counters:
  - on the capture edge, increment the counter matching the code (1→div, 2→mem, 3→opc);
  - counters saturate at all-ones;
  - reserved codes are captured and reported but not counted.
- err_lost is set at any edge where state != RUN and cpu_error != 0. It is not set on the capture edge itself.
- pcu_clear_cnt zeroes all counters and err_lost at the edge. If clear and a capture occur on the same edge, clear wins: counters become 0 and the new error is still captured and reported. Clear does not affect state.
- pcu_ready asserted when err_valid=0 has no effect.
- Asserting rst mid-sequence in any state immediately returns to RUN with all outputs 0, and any pending record is lost.

Optional Feature:
ERROR_LOG_EN:
- Defined: a 4-entry circular log of {err_code, err_pc} is written on every capture edge at write pointer wp, then wp increments (wraps 3→0).
  - log_rdata = entry[(wp - 1 - log_idx) mod 4], so log_idx=0 returns the newest entry.
  - Unwritten entries read 0.
  - pcu_clear_cnt also clears the log and wp.
- Undefined: log storage is removed; log_idx is ignored and log_rdata is tied to 0. Ports remain present in both builds.

Test Plan:
- Reset, then cpu_error=2 with err_pc=0x0000_0040 for one cycle → next cycle cpu_stall=1, err_valid=1, err_code=2, err_pc_out=0x40, cnt_mem=1.
- Hold pcu_ready=0 for 5 cycles in REPORT, toggling cpu_error=3 → record stays 2/0x40, err_lost=1. Then pcu_ready=1 → err_valid=0 next cycle, state HALT.
- In HALT, pulse pcu_resume with DRAIN_CYC=3 → cpu_stall stays 1 for exactly 3 more cycles, then 0; a cpu_error=1 on the first RUN cycle is captured, cnt_div=1.
- With CNT_W=2, inject 5 opcode errors, each fully handshaked → cnt_opc=3 (saturated). Then pcu_clear_cnt coincident with a 6th capture → cnt_opc=0, err_valid=1, err_code=3.
- Assert rst while in DRAIN → all outputs 0 immediately (asynchronous), state RUN after release; cpu_error=7 → captured, reported, no counter changes.
- ERROR_LOG_EN: capture codes 1,2,3,1,2 with PCs 0x10..0x50 → log_idx=0 gives {2,0x50}, log_idx=3 gives {2,0x20}. Without the macro → log_rdata=0.
